// File: rtl/mips_dbg_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_dbg_sequencer_if : UART FIFO / pipeline debug-port bundle             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mips_dbg_sequencer_if #(
  parameter int NB_REG  = 32,
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] rx_data;
  logic               rx_valid;
  logic               tx_full;
  logic [NB_REG-1:0]  reg_data;
  logic [NB_REG-1:0]  mem_data;
  logic               halt;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_wr;
  logic               w_mem;
  logic [NB_REG-1:0]  inst;
  logic [NB_REG-1:0]  addr_inst;
  logic               enable;
  logic               reset_mips;

  modport master (
    input  rx_data, rx_valid, tx_full, reg_data, mem_data, halt,
    output tx_data, tx_wr, w_mem, inst, addr_inst, enable, reset_mips
  );

  modport slave (
    output rx_data, rx_valid, tx_full, reg_data, mem_data, halt,
    input  tx_data, tx_wr, w_mem, inst, addr_inst, enable, reset_mips
  );
endinterface
`default_nettype wire

// File: rtl/mips_dbg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mips_dbg_sequencer : host command sequencer for the MIPS debug port        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mips_dbg_sequencer #(
  parameter int NB_REG      = 32,
  parameter int NB_BYTE     = 8,
  parameter int N_REGS      = 32,
  parameter int N_MEM_WORDS = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  mips_dbg_sequencer_if.master  dbg
);
  localparam int BYTES_PER_WORD = NB_REG / NB_BYTE;
  localparam int BC_W           = $clog2(BYTES_PER_WORD);
  localparam int MAX_N          = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
  localparam int IDX_W          = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] ACK_BYTE  = NB_BYTE'(8'h06);
  localparam logic [BC_W-1:0]    LAST_BYTE = BC_W'(BYTES_PER_WORD - 1);
  localparam logic [IDX_W-1:0]   LAST_REG  = IDX_W'(N_REGS - 1);
  localparam logic [IDX_W-1:0]   LAST_MEM  = IDX_W'(N_MEM_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, LD_CNT, LD_BYTE, LD_WRITE, LD_RST, LD_ACK,
    RUN, STEP, D_ADDR, D_WAIT, D_SEND, D_TRAIL
  } state_t;

  state_t             state, state_nx;
  logic [8:0]         word_cnt, word_cnt_nx;
  logic [8:0]         word_idx, word_idx_nx;
  logic [IDX_W-1:0]   dump_idx, dump_idx_nx;
  logic               mem_phase, mem_phase_nx;
  logic [BC_W-1:0]    byte_cnt, byte_cnt_nx;
  logic [NB_REG-1:0]  shreg, shreg_nx;
  logic [NB_REG-1:0]  addr_hold, addr_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_cnt  <= '0;
      word_idx  <= '0;
      dump_idx  <= '0;
      mem_phase <= 1'b0;
      byte_cnt  <= '0;
      shreg     <= '0;
      addr_hold <= '0;
    end else begin
      state     <= state_nx;
      word_cnt  <= word_cnt_nx;
      word_idx  <= word_idx_nx;
      dump_idx  <= dump_idx_nx;
      mem_phase <= mem_phase_nx;
      byte_cnt  <= byte_cnt_nx;
      shreg     <= shreg_nx;
      addr_hold <= addr_out;
    end
  end

  always_comb begin
    state_nx       = state;
    word_cnt_nx    = word_cnt;
    word_idx_nx    = word_idx;
    dump_idx_nx    = dump_idx;
    mem_phase_nx   = mem_phase;
    byte_cnt_nx    = byte_cnt;
    shreg_nx       = shreg;
    addr_out       = addr_hold;
    dbg.tx_data    = '0;
    dbg.tx_wr      = 1'b0;
    dbg.w_mem      = 1'b0;
    dbg.inst       = '0;
    dbg.enable     = 1'b0;
    dbg.reset_mips = 1'b0;

    unique case (state)
      IDLE: begin
        if (dbg.rx_valid) begin
          if (dbg.rx_data == CMD_LOAD)      state_nx = LD_CNT;
          else if (dbg.rx_data == CMD_RUN)  state_nx = RUN;
          else if (dbg.rx_data == CMD_STEP) state_nx = STEP;
        end
      end
      LD_CNT: begin
        if (dbg.rx_valid) begin
          // A count byte of zero stands for a full 256-word image
          word_cnt_nx = (dbg.rx_data == '0) ? 9'd256 : 9'(dbg.rx_data);
          word_idx_nx = '0;
          byte_cnt_nx = '0;
          state_nx    = LD_BYTE;
        end
      end
      LD_BYTE: begin
        if (dbg.rx_valid) begin
          shreg_nx    = {shreg[NB_REG-NB_BYTE-1:0], dbg.rx_data};
          byte_cnt_nx = byte_cnt + 1'b1;
          if (byte_cnt == LAST_BYTE) state_nx = LD_WRITE;
        end
      end
      LD_WRITE: begin
        dbg.w_mem   = 1'b1;
        dbg.inst    = shreg;
        addr_out    = NB_REG'({word_idx, 2'b00});
        word_idx_nx = word_idx + 9'd1;
        state_nx    = (word_idx == word_cnt - 9'd1) ? LD_RST : LD_BYTE;
      end
      LD_RST: begin
        dbg.reset_mips = 1'b1;
        state_nx       = LD_ACK;
      end
      LD_ACK: begin
        dbg.tx_data = ACK_BYTE;
        dbg.tx_wr   = !dbg.tx_full;
        if (!dbg.tx_full) state_nx = IDLE;
      end
      // Enable is gated by halt in the same cycle so a retired HALT never advances
      RUN: begin
        dbg.enable = !dbg.halt;
        if (dbg.halt) state_nx = D_ADDR;
      end
      STEP: begin
        dbg.enable = !dbg.halt;
        state_nx   = D_ADDR;
      end
      D_ADDR: begin
        addr_out = mem_phase ? NB_REG'({dump_idx, 2'b00}) : NB_REG'(dump_idx);
        state_nx = D_WAIT;
      end
      D_WAIT: begin
        shreg_nx    = mem_phase ? dbg.mem_data : dbg.reg_data;
        byte_cnt_nx = '0;
        state_nx    = D_SEND;
      end
      D_SEND: begin
        dbg.tx_data = shreg[NB_REG-1 -: NB_BYTE];
        dbg.tx_wr   = !dbg.tx_full;
        if (!dbg.tx_full) begin
          shreg_nx    = shreg << NB_BYTE;
          byte_cnt_nx = byte_cnt + 1'b1;
          if (byte_cnt == LAST_BYTE) begin
            state_nx = D_ADDR;
            if (!mem_phase) begin
              if (dump_idx == LAST_REG) begin
                mem_phase_nx = 1'b1;
                dump_idx_nx  = '0;
              end else begin
                dump_idx_nx = dump_idx + 1'b1;
              end
            end else if (dump_idx == LAST_MEM) begin
              mem_phase_nx = 1'b0;
              dump_idx_nx  = '0;
              state_nx     = D_TRAIL;
            end else begin
              dump_idx_nx = dump_idx + 1'b1;
            end
          end
        end
      end
      D_TRAIL: begin
        dbg.tx_data = NB_BYTE'(dbg.halt);
        dbg.tx_wr   = !dbg.tx_full;
        if (!dbg.tx_full) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    dbg.addr_inst = addr_out;
  end
endmodule
`default_nettype wire

// File: tb/tb_mips_dbg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mips_dbg_sequencer : self-checking bench with RAM model and byte model  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mips_dbg_sequencer;
  localparam int NB_REG      = 32;
  localparam int NB_BYTE     = 8;
  localparam int N_REGS      = 32;
  localparam int N_MEM_WORDS = 16;
  localparam int DUMP_LEN    = 4 * (N_REGS + N_MEM_WORDS) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_dbg_sequencer_if #(.NB_REG(NB_REG), .NB_BYTE(NB_BYTE)) ifc ();

  mips_dbg_sequencer #(
    .NB_REG(NB_REG), .NB_BYTE(NB_BYTE), .N_REGS(N_REGS), .N_MEM_WORDS(N_MEM_WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dbg (ifc)
  );

  bit hold_full = 1'b0;
  bit bp_mode   = 1'b0;
  bit rnd_full  = 1'b0;
  assign ifc.tx_full = hold_full | (bp_mode & rnd_full);

  initial forever begin
    @(posedge clk); #1;
    rnd_full = 1'($urandom_range(0, 1));
  end

  // Register file and data memory with one-cycle read latency
  logic [31:0] reg_model [N_REGS];
  logic [31:0] mem_model [N_MEM_WORDS];
  always @(posedge clk) begin
    ifc.reg_data <= reg_model[ifc.addr_inst[4:0]];
    ifc.mem_data <= mem_model[ifc.addr_inst[5:2]];
  end

  int          cyc = 0;
  logic [7:0]  tx_q [$];
  logic [63:0] wr_q [$];
  int          en_cnt, rst_pulses, wr_full_cnt, last_wr_cyc, rst_cyc;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] ld_words [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.tx_wr) begin
        tx_q.push_back(ifc.tx_data);
        if (ifc.tx_full) wr_full_cnt++;
      end
      if (ifc.w_mem) begin
        wr_q.push_back({ifc.addr_inst, ifc.inst});
        last_wr_cyc = cyc;
      end
      if (ifc.reset_mips) begin
        rst_pulses++;
        rst_cyc = cyc;
      end
      if (ifc.enable) en_cnt++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    tx_q.delete();
    wr_q.delete();
    en_cnt = 0; rst_pulses = 0; wr_full_cnt = 0; last_wr_cyc = -100; rst_cyc = -200;
  endtask

  task automatic rand_models();
    foreach (reg_model[i]) reg_model[i] = $urandom;
    foreach (mem_model[i]) mem_model[i] = $urandom;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    ifc.rx_data  = b;
    ifc.rx_valid = 1'b1;
    @(posedge clk); #1;
    ifc.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget, input string name);
    int c = 0;
    while (tx_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check({name, "_wait"}, 64'(tx_q.size() >= n), 64'd1);
  endtask

  // Expected stream: every register then every memory word, MSB first, then the halt flag
  function automatic int dump_mismatch(input int base, input bit halt_v);
    logic [7:0] e [$];
    int mism = 0;
    for (int i = 0; i < N_REGS + N_MEM_WORDS; i++) begin
      logic [31:0] w = (i < N_REGS) ? reg_model[i] : mem_model[i - N_REGS];
      for (int b = 3; b >= 0; b--) e.push_back(w[8*b +: 8]);
    end
    e.push_back({7'd0, halt_v});
    for (int i = 0; i < e.size(); i++)
      if (base + i >= tx_q.size() || tx_q[base + i] !== e[i]) mism++;
    return mism;
  endfunction

  task automatic check_dump(input string name, input int base, input bit halt_v);
    check({name, "_bad_bytes"}, 64'(dump_mismatch(base, halt_v)), 64'd0);
    check({name, "_trailer"}, 64'(tx_q.size() > base + DUMP_LEN - 1 ? tx_q[base + DUMP_LEN - 1] : 8'hEE),
          64'(halt_v));
  endtask

  task automatic do_load(input int n, input string name);
    int mism = 0;
    clear_mon();
    send_byte(8'h4C);
    send_byte(8'(n));
    for (int k = 0; k < n; k++)
      for (int b = 3; b >= 0; b--) send_byte(ld_words[k][8*b +: 8]);
    wait_tx(1, 200, name);
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < n && k < wr_q.size(); k++)
      if (wr_q[k] !== {32'(4 * k), ld_words[k]}) mism++;
    check({name, "_writes"}, 64'(wr_q.size()), 64'(n));
    check({name, "_bad_writes"}, 64'(mism), 64'd0);
    check({name, "_rst_pulses"}, 64'(rst_pulses), 64'd1);
    check({name, "_rst_after_write"}, 64'(rst_cyc - last_wr_cyc), 64'd1);
    check({name, "_ack_len"}, 64'(tx_q.size()), 64'd1);
    check({name, "_ack"}, 64'(tx_q.size() > 0 ? tx_q[0] : 8'hEE), 64'h06);
    check({name, "_enable"}, 64'(en_cnt), 64'd0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         halt;
    bit         bp;
    int         exp_en;
    int         exp_tx;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.rx_data  = '0;
    ifc.rx_valid = 1'b0;
    ifc.halt     = 1'b0;
    rand_models();
    clear_mon();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_wr", 64'(ifc.tx_wr), 64'd0);
    check("reset_tx_data", 64'(ifc.tx_data), 64'd0);
    check("reset_w_mem", 64'(ifc.w_mem), 64'd0);
    check("reset_inst", 64'(ifc.inst), 64'd0);
    check("reset_addr", 64'(ifc.addr_inst), 64'd0);
    check("reset_enable", 64'(ifc.enable), 64'd0);
    check("reset_mips", 64'(ifc.reset_mips), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    ld_words = '{32'h12345678, 32'h9ABCDEF0};
    do_load(2, "load2");

    vecs = '{
      '{8'h00, 1'b0, 1'b0, 0, 0},
      '{8'hFF, 1'b0, 1'b0, 0, 0},
      '{8'h53, 1'b0, 1'b0, 1, DUMP_LEN},
      '{8'h53, 1'b1, 1'b0, 0, DUMP_LEN},
      '{8'h52, 1'b1, 1'b0, 0, DUMP_LEN},
      '{8'h53, 1'b0, 1'b1, 1, DUMP_LEN},
      '{8'h41, 1'b0, 1'b0, 0, 0}
    };
    for (int v = 0; v < 7; v++) begin
      string nm = $sformatf("vec%0d", v);
      rand_models();
      ifc.halt = vecs[v].halt;
      bp_mode  = vecs[v].bp;
      clear_mon();
      send_byte(vecs[v].cmd);
      if (vecs[v].exp_tx > 0) wait_tx(vecs[v].exp_tx, 3000, nm);
      else repeat (30) @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      bp_mode = 1'b0;
      check({nm, "_enable"}, 64'(en_cnt), 64'(vecs[v].exp_en));
      check({nm, "_tx_len"}, 64'(tx_q.size()), 64'(vecs[v].exp_tx));
      if (vecs[v].exp_tx > 0) check_dump(nm, 0, vecs[v].halt);
      check({nm, "_w_mem"}, 64'(wr_q.size()), 64'd0);
      check({nm, "_rst_pulses"}, 64'(rst_pulses), 64'd0);
      check({nm, "_wr_while_full"}, 64'(wr_full_cnt), 64'd0);
    end

    // Run until halt after ten enabled cycles, with a held stall then random backpressure
    begin
      int c = 0;
      int sz;
      rand_models();
      ifc.halt = 1'b0;
      clear_mon();
      send_byte(8'h52);
      while (en_cnt < 10 && c < 200) begin
        @(posedge clk); #1;
        c++;
      end
      ifc.halt = 1'b1;
      wait_tx(20, 1000, "run_mid");
      hold_full = 1'b1;
      sz = tx_q.size();
      repeat (5) @(posedge clk);
      #1;
      check("run_stall_no_bytes", 64'(tx_q.size()), 64'(sz));
      hold_full = 1'b0;
      bp_mode   = 1'b1;
      wait_tx(DUMP_LEN, 3000, "run");
      repeat (10) @(posedge clk);
      #1;
      bp_mode = 1'b0;
      check("run_enable", 64'(en_cnt), 64'd10);
      check("run_tx_len", 64'(tx_q.size()), 64'(DUMP_LEN));
      check_dump("run", 0, 1'b1);
      check("run_wr_while_full", 64'(wr_full_cnt), 64'd0);
    end

    // Two consecutive steps while not halted
    rand_models();
    ifc.halt = 1'b0;
    clear_mon();
    send_byte(8'h53);
    wait_tx(DUMP_LEN, 3000, "step1");
    repeat (5) @(posedge clk);
    send_byte(8'h53);
    wait_tx(2 * DUMP_LEN, 3000, "step2");
    repeat (10) @(posedge clk);
    #1;
    check("step2_enable", 64'(en_cnt), 64'd2);
    check("step2_tx_len", 64'(tx_q.size()), 64'(2 * DUMP_LEN));
    check_dump("step2_second", DUMP_LEN, 1'b0);

    // Randomised short loads
    for (int t = 0; t < 3; t++) begin
      int n = $urandom_range(1, 6);
      ld_words.delete();
      for (int k = 0; k < n; k++) ld_words.push_back($urandom);
      do_load(n, $sformatf("rload%0d", t));
    end

    // Count byte zero means 256 words
    ld_words.delete();
    for (int k = 0; k < 256; k++) ld_words.push_back($urandom);
    do_load(256, "load256");
    check("load256_last_addr", 64'(wr_q.size() == 256 ? wr_q[255][63:32] : 32'hDEAD), 64'h3FC);

    // Reset part-way through a word
    clear_mon();
    send_byte(8'h4C);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_w_mem", 64'(ifc.w_mem), 64'd0);
    check("midrst_tx_wr", 64'(ifc.tx_wr), 64'd0);
    check("midrst_addr", 64'(ifc.addr_inst), 64'd0);
    check("midrst_enable", 64'(ifc.enable), 64'd0);
    check("midrst_reset_mips", 64'(ifc.reset_mips), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ld_words = '{32'h11223344};
    do_load(1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mips_dbg_sequencer.md
Name: mips_dbg_sequencer

Overview:
Command sequencer between the UART byte stream and the MIPS pipeline debug port. It decodes single-byte host commands and performs four jobs:
- loads instruction memory word by word,
- resets the core,
- runs the core to halt, or single-steps it,
- streams register-file and data-memory contents back as bytes.
It sits between the UART RX/TX FIFOs and the pipeline's dunit inputs and outputs, and it is the only driver of pipeline clock-enable and debug writes.

Parameters:
NB_REG, 32, data/instruction/address width
NB_BYTE, 8, UART byte width
N_REGS, 32, registers dumped per dump
N_MEM_WORDS, 16, data-memory words dumped per dump (1..256)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_rx_data  in  NB_BYTE  received byte, valid when i_rx_valid
i_rx_valid  in  1  one-cycle strobe per received byte
i_tx_full  in  1  TX FIFO full; no write allowed while high
i_reg_data  in  NB_REG  register file read data at o_addr_inst, 1-cycle latency
i_mem_data  in  NB_REG  data memory read data at o_addr_inst, 1-cycle latency
i_halt  in  1  pipeline has retired HALT
o_tx_data  out  NB_BYTE  byte to TX FIFO
o_tx_wr  out  1  one-cycle TX FIFO write strobe
o_w_mem  out  1  one-cycle instruction-memory write strobe
o_inst  out  NB_REG  instruction word to write
o_addr_inst  out  NB_REG  debug address (imem/regfile/dmem)
o_enable  out  1  pipeline clock enable
o_reset_mips  out  1  one-cycle core reset pulse

Behaviour:
- Reset: all outputs 0, state IDLE, counters and shift registers 0. Reset at any point aborts the current operation within one cycle; partially assembled words are discarded.
- Command bytes in IDLE: 'L'=0x4C load, 'R'=0x52 run, 'S'=0x53 step. Any other byte is ignored and the block stays in IDLE. Bytes received outside IDLE, LD_CNT and LD_BYTE are dropped.
- LOAD:
  - IDLE -> LD_CNT. The next byte N sets the word count; N=0 means 256.
  - LD_BYTE shifts in 4 bytes MSB first.
  - On the 4th byte, go to LD_WRITE: for exactly 1 cycle, o_inst=word, o_addr_inst=4*k (k=word index from 0), o_w_mem=1. Then k+1.
  - After word N-1, go to LD_RST: o_reset_mips=1 for 1 cycle.
  - Then send ACK byte 0x06 and return to IDLE.
- RUN:
  - If i_halt=1 on entry, go straight to DUMP.
  - Otherwise o_enable=1 every cycle until the first cycle i_halt is sampled 1. o_enable drops in that same cycle (combinational gate on i_halt), then DUMP.
- STEP:
  - o_enable=1 for exactly 1 cycle, then DUMP.
  - If i_halt=1 on entry, no enable pulse; go straight to DUMP.
- DUMP:
  - Registers: for i=0..N_REGS-1, drive o_addr_inst=i for 1 cycle (D_ADDR). Capture i_reg_data the next cycle (D_WAIT).
  - Memory: then for j=0..N_MEM_WORDS-1, o_addr_inst=4*j and capture i_mem_data.
  - Each captured word is sent as 4 bytes MSB first (D_SEND).
  - Then one trailer byte: 0x01 if i_halt else 0x00. Return to IDLE.
  - o_enable stays 0 for the whole dump.
- TX handshake: o_tx_wr=1 only in cycles where i_tx_full=0; each strobe transfers exactly one byte. While full, the byte is held and the FSM stalls without skipping or duplicating. Minimum spacing is one byte per cycle.
- Counters: k is 9 bits to allow 256 words. The dump index is clog2(max(N_REGS, N_MEM_WORDS)) bits. No wrap is observable because terminal counts are compared exactly.
- o_addr_inst: holds its last value in IDLE, RUN and STEP; upper unused bits are 0.
- Total dump length is 4*(N_REGS+N_MEM_WORDS)+1 bytes: 193 with the defaults.

Test Plan:
1. Load: bytes 0x4C,0x02, 12 34 56 78, 9A BC DE F0 -> two o_w_mem pulses, (addr 0, 0x12345678) then (addr 4, 0x9ABCDEF0); then one o_reset_mips pulse; then TX 0x06; no o_enable.
2. Run: 'R' with i_halt rising 10 cycles after the command -> o_enable high exactly 10 cycles; then 193 TX bytes; last byte 0x01; reg i's bytes match the model value at addr i.
3. Step, not halted: 'S' -> exactly one o_enable cycle; 193 bytes; trailer 0x00. A second 'S' -> one more enable pulse.
4. Backpressure: hold i_tx_full=1 for 5 cycles mid-dump and toggle it randomly afterwards -> byte sequence identical to the unstalled run; no o_tx_wr while full.
5. Garbage and count rollover: 0x00, 0xFF in IDLE -> no outputs. Load with N=0 -> 256 writes, last addr 0x3FC.
6. Reset mid-load: assert i_reset after 2 word bytes -> all outputs 0. A new load of 1 word writes addr 0 with the correct value.
